rv32i_mem_loader: RTL and testbench
===================================

// Module: rv32i_mem_loader
// PURPOSE
//   Bus writer that fills the shared dmem with a program image before the rv32i core runs.
//   Accepts a framed byte stream: 16-bit start address, 16-bit byte count, then payload.
//   Writes each payload byte into dmem through the core's data-write port signals.
//   Holds the core in reset until the image is complete, then releases it.
// PARAMETERS
//   DATA_WIDTH  32  width of daddr/ddout (matches rv32i data port)
//   ADDR_WIDTH  16  significant address bits; the upper daddr bits are driven 0
//   AUTO_START  1   1: first load is armed out of reset; 0: waits for start pulse
// PORTS
//   clk       in   1           single clock, all state on rising edge
//   rst_n     in   1           reset, asynchronous, active-low
//   start     in   1           one-cycle pulse: re-arm loader from DONE/ERROR
//   s_data    in   8           stream byte
//   s_valid   in   1           s_data valid
//   s_ready   out  1           loader accepts s_data; transfer = s_valid & s_ready
//   daddr     out  DATA_WIDTH  dmem byte address
//   ddout     out  DATA_WIDTH  dmem write data; byte in [7:0], [31:8] = 0
//   dwe0      out  1           byte-write enable (only write enable used)
//   dwe1      out  1           halfword-write enable, tied 0
//   dwe2      out  1           word-write enable, tied 0
//   core_rst  out  1           active-high reset to rv32i core
//   busy      out  1           load in progress (HDR/DATA/WRITE/CSUM states)
//   done      out  1           image written and core released
//   err       out  1           load aborted
// BEHAVIOUR
//   Reset (rst_n=0, async): s_ready=0, daddr=0, ddout=0, dwe0..2=0, core_rst=1, busy=0,
//     done=0, err=0. State = HDR0 if AUTO_START else IDLE.
//   States: IDLE, HDR0, HDR1, HDR2, HDR3, DATA, WRITE, CSUM, DONE, ERROR.
//   IDLE: s_ready=0; core_rst=1. Leave on start -> HDR0.
//   HDR0..HDR3: s_ready=1; each accepted byte -> next state.
//     Order: addr[15:8], addr[7:0], cnt[15:8], cnt[7:0] (big-endian).
//   After HDR3:
//     cnt==0 -> CSUM if LOADER_CHECKSUM_EN is defined, else DONE.
//     cnt!=0 -> DATA.
//   DATA: s_ready=1. An accepted byte is registered: daddr=addr, ddout={24'b0,byte}, dwe0=1.
//     Then go to WRITE.
//   WRITE: one cycle with dwe0=1 and s_ready=0; addr+=1, cnt-=1.
//     Exit to DATA if cnt!=0, else CSUM/DONE. Throughput is 1 byte per 2 cycles.
//   dwe0 is a registered one-cycle pulse; dmem captures it on the next rising edge.
//   addr wraps 0xFFFF -> 0x0000 with no error.
//   DONE: core_rst=0 on the first cycle in DONE (registered); done=1; s_ready=0.
//     Bytes presented in DONE are not consumed.
//   start in DONE/ERROR: core_rst=1, done=0, err=0, next HDR0. start in any other state is ignored.
//   s_valid=0 in any state: hold state; no timeout.
//   rst_n asserted mid-load: partial image stays in dmem; loader returns to its reset state.
// CONFIGURATION
//   LOADER_CHECKSUM_EN defined:
//     - Running 8-bit sum of all header and payload bytes (mod 256).
//     - CSUM state accepts one trailing byte. If sum + byte == 8'h00 -> DONE.
//     - Otherwise -> ERROR: err=1 and core_rst stays 1.
//   LOADER_CHECKSUM_EN undefined: no CSUM state, no accumulator; err is tied 0.
// STRUCTURE
//   Package rv32i_loader_pkg contains:
//     - state enum loader_state_t
//     - HDR_BYTES=4
//     - byte/address typedefs shared with dmem users
//   Single module, no sub-module: the FSM plus address/count/checksum registers are
//     small enough to stay flat.
// TESTING
//   1. Reset with AUTO_START=1; stream 00 00 00 04 13 05 A0 00 ->
//      mem[0..3] = 13 05 A0 00; core_rst falls after the 4th WRITE; done=1.
//   2. Header C0 00 00 00 -> no dwe0 pulse; DONE (or CSUM, where byte 0x40 sums to 0).
//   3. Header FF FE 00 03, bytes AA BB CC ->
//      mem[FFFE]=AA, mem[FFFF]=BB, mem[0000]=CC (wrap).
//   4. Random s_valid gaps plus a mid-payload rst_n pulse ->
//      resets to HDR0 state and outputs; a following reload writes the correct image.
//   5. CHECKSUM_EN: 00 10 00 01 55 then 9A -> DONE; the same stream with 9B -> ERROR,
//      err=1, core_rst=1; start then re-arms and clears err.
//   6. In DONE, s_valid=1 held -> s_ready stays 0; no writes; start pulse re-arms and
//      core_rst=1 the next cycle.

Source files
------------

// File: rtl/rv32i_loader_pkg.sv
// Shared types for the rv32i program-image loader and dmem users.
// Loader states, header length and byte/address types.
package rv32i_loader_pkg;

  localparam int HDR_BYTES = 4;

  typedef logic [7:0]  byte_t;
  typedef logic [15:0] addr_t;

  typedef enum logic [3:0] {
    IDLE,
    HDR0,
    HDR1,
    HDR2,
    HDR3,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/rv32i_mem_loader.sv
// Streams a framed program image into dmem, holding the core in reset until done.
// Optional trailing checksum byte: define LOADER_CHECKSUM_EN.
module rv32i_mem_loader
  import rv32i_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter bit AUTO_START = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] daddr,
  output logic [DATA_WIDTH-1:0] ddout,
  output logic                  dwe0,
  output logic                  dwe1,
  output logic                  dwe2,
  output logic                  core_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  loader_state_t state;
  addr_t         addr;
  addr_t         cnt;
  logic          xfer;

  assign xfer = s_valid & s_ready;
  assign dwe1 = 1'b0;
  assign dwe2 = 1'b0;

`ifdef LOADER_CHECKSUM_EN
  byte_t sum;
  logic  err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= AUTO_START ? HDR0 : IDLE;
      addr     <= '0;
      cnt      <= '0;
      s_ready  <= 1'b0;
      daddr    <= '0;
      ddout    <= '0;
      dwe0     <= 1'b0;
      core_rst <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum      <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      dwe0 <= 1'b0;
      unique case (state)
        IDLE: begin
          s_ready  <= 1'b0;
          core_rst <= 1'b1;
          if (start) begin
            state   <= HDR0;
            s_ready <= 1'b1;
            busy    <= 1'b1;
          end
        end
        HDR0, HDR1, HDR2, HDR3: begin
          // ready comes up one cycle after reset/arming
          s_ready <= 1'b1;
          busy    <= 1'b1;
          if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
            sum <= sum + s_data;
`endif
            unique case (state)
              HDR0: begin
                addr[15:8] <= s_data;
                state      <= HDR1;
              end
              HDR1: begin
                addr[7:0] <= s_data;
                state     <= HDR2;
              end
              HDR2: begin
                cnt[15:8] <= s_data;
                state     <= HDR3;
              end
              default: begin
                cnt[7:0] <= s_data;
                if ({cnt[15:8], s_data} != 16'd0) begin
                  state <= DATA;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                  state <= CSUM;
`else
                  state    <= DONE;
                  s_ready  <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  core_rst <= 1'b0;
`endif
                end
              end
            endcase
          end
        end
        DATA: begin
          if (xfer) begin
            daddr   <= DATA_WIDTH'(addr[ADDR_WIDTH-1:0]);
            ddout   <= DATA_WIDTH'(s_data);
            dwe0    <= 1'b1;
            s_ready <= 1'b0;
            state   <= WRITE;
`ifdef LOADER_CHECKSUM_EN
            sum <= sum + s_data;
`endif
          end
        end
        WRITE: begin
          addr <= addr + 16'd1;
          cnt  <= cnt - 16'd1;
          if (cnt != 16'd1) begin
            state   <= DATA;
            s_ready <= 1'b1;
          end else begin
`ifdef LOADER_CHECKSUM_EN
            state   <= CSUM;
            s_ready <= 1'b1;
`else
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            core_rst <= 1'b0;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          s_ready <= 1'b1;
          if (xfer) begin
            s_ready <= 1'b0;
            busy    <= 1'b0;
            if (byte_t'(sum + s_data) == 8'h00) begin
              state    <= DONE;
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              state <= ERROR;
              err_q <= 1'b1;
            end
          end
        end
`endif
        DONE, ERROR: begin
          s_ready <= 1'b0;
          if (start) begin
            state    <= HDR0;
            s_ready  <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            core_rst <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum   <= '0;
            err_q <= 1'b0;
`endif
          end
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mem_loader.sv
// Scoreboard bench for rv32i_mem_loader: expected dmem writes are queued
// by the stimulus and checked by a forked monitor on each dwe0 pulse.
module tb_rv32i_mem_loader;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] daddr;
  logic [31:0] ddout;
  logic        dwe0;
  logic        dwe1;
  logic        dwe2;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        err;

  wr_t         sb[$];
  int          checks;
  int          errors;
  bit          use_gaps;
  logic [7:0]  csum;

  rv32i_mem_loader #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(16),
    .AUTO_START(1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .daddr   (daddr),
    .ddout   (ddout),
    .dwe0    (dwe0),
    .dwe1    (dwe1),
    .dwe2    (dwe2),
    .core_rst(core_rst),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    if (use_gaps) begin
      s_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    s_data  = b;
    s_valid = 1'b1;
    csum    = csum + b;
    while (!s_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!s_ready) chk("send_timeout", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
    wr_t w;
    w.a = {16'h0, a};
    w.d = {24'h0, d};
    sb.push_back(w);
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [7:0] pl[$]);
    logic [15:0] n;
    n    = 16'(pl.size());
    csum = 8'h00;
    send(a[15:8]);
    send(a[7:0]);
    send(n[15:8]);
    send(n[7:0]);
    foreach (pl[i]) begin
      expect_wr(a + 16'(i), pl[i]);
      send(pl[i]);
    end
`ifdef LOADER_CHECKSUM_EN
    send(8'h00 - csum);
`endif
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || err) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("end_reached", 32'(done | err), 32'd1);
  endtask

  task automatic check_done(input string nm);
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_core_rst"}, 32'(core_rst), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("rearm_core_rst", 32'(core_rst), 32'd1);
    chk("rearm_done", 32'(done), 32'd0);
    chk("rearm_err", 32'(err), 32'd0);
    chk("rearm_busy", 32'(busy), 32'd1);
  endtask

  task automatic check_reset_outs(input string nm);
    chk({nm, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({nm, "_daddr"}, daddr, 32'd0);
    chk({nm, "_ddout"}, ddout, 32'd0);
    chk({nm, "_dwe"}, {29'd0, dwe2, dwe1, dwe0}, 32'd0);
    chk({nm, "_core_rst"}, 32'(core_rst), 32'd1);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    use_gaps = 1'b0;
    csum     = 8'h00;
    rst_n    = 1'b0;
    start    = 1'b0;
    s_valid  = 1'b0;
    s_data   = 8'h00;

    fork
      forever begin
        wr_t e;
        @(negedge clk);
        if (rst_n && dwe0) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write got %h:%h want none",
                     daddr, ddout);
          end else begin
            e = sb.pop_front();
            chk("wr_addr", daddr, e.a);
            chk("wr_data", ddout, e.d);
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("autostart_ready", 32'(s_ready), 32'd1);

    // 1: basic four-byte image at 0
    send_frame(16'h0000, '{8'h13, 8'h05, 8'hA0, 8'h00});
    wait_end();
    check_done("t1");

    // 6: bytes offered in DONE are ignored
    s_data  = 8'h77;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("done_hold_ready", 32'(s_ready), 32'd0);
    end
    chk("done_hold_done", 32'(done), 32'd1);
    s_valid = 1'b0;
    pulse_start();

    // 2: empty image
    send_frame(16'hC000, '{});
    wait_end();
    check_done("t2");
    pulse_start();

    // 3: address wrap
    send_frame(16'hFFFE, '{8'hAA, 8'hBB, 8'hCC});
    wait_end();
    check_done("t3");
    pulse_start();

    // 4: gaps and reset mid-payload, then a clean reload
    use_gaps = 1'b1;
    csum     = 8'h00;
    send(8'h00);
    send(8'h20);
    send(8'h00);
    send(8'h04);
    expect_wr(16'h0020, 8'h11);
    send(8'h11);
    expect_wr(16'h0021, 8'h22);
    send(8'h22);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_reset_outs("midrst");
    chk("midrst_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready", 32'(s_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd1);
    send_frame(16'h0020, '{8'h11, 8'h22, 8'h33, 8'h44});
    wait_end();
    check_done("t4");
    use_gaps = 1'b0;

`ifdef LOADER_CHECKSUM_EN
    // 5: explicit checksum pass and fail
    pulse_start();
    send(8'h00);
    send(8'h10);
    send(8'h00);
    send(8'h01);
    expect_wr(16'h0010, 8'h55);
    send(8'h55);
    send(8'h9A);
    wait_end();
    check_done("t5ok");
    chk("t5ok_err", 32'(err), 32'd0);
    pulse_start();
    send(8'h00);
    send(8'h10);
    send(8'h00);
    send(8'h01);
    expect_wr(16'h0010, 8'h55);
    send(8'h55);
    send(8'h9B);
    wait_end();
    chk("t5bad_err", 32'(err), 32'd1);
    chk("t5bad_core_rst", 32'(core_rst), 32'd1);
    chk("t5bad_done", 32'(done), 32'd0);
    chk("t5bad_sb_empty", 32'(sb.size()), 32'd0);
    pulse_start();
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
